// File: rtl/vga_sprite_gen.sv
// ============================================================================
// vga_sprite_gen : bouncing square sprite overlaid on a VGA pixel stream,
//                  two-stage pixel pipeline; optional white frame border
//                  when VGA_BORDER_EN is defined.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module vga_sprite_gen #(
  parameter int          H_DISP    = 640,
  parameter int          V_DISP    = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter logic [11:0] BOX_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR  = 12'h00F
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        disp_active_i,
  input  logic [10:0] xcol_i,
  input  logic [10:0] yrow_i,
  input  logic        move_en_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [3:0]  red_o,
  output logic [3:0]  green_o,
  output logic [3:0]  blue_o,
  output logic        frame_tick_o
);

  localparam logic [12:0] c_H_DISP = 13'(H_DISP);
  localparam logic [12:0] c_V_DISP = 13'(V_DISP);
  localparam logic [12:0] c_BOX    = 13'(BOX_SIZE);
  localparam logic [12:0] c_STEP   = 13'(STEP);
  localparam logic [10:0] c_X_MAX  = 11'(H_DISP - BOX_SIZE);
  localparam logic [10:0] c_Y_MAX  = 11'(V_DISP - BOX_SIZE);
  localparam logic [10:0] c_STEP11 = 11'(STEP);

  logic [10:0] r_box_x, r_box_y;
  logic        r_dir_x, r_dir_y;
  logic        r_vs_prev, r_tick;
  logic        r_hit, r_act;
  logic [1:0]  r_hs_d, r_vs_d;
  logic [11:0] r_rgb;

  logic [10:0] w_nx, w_ny;
  logic        w_ndx, w_ndy;
  logic        w_tick, w_hit;
  logic [12:0] w_bx, w_by, w_xc, w_yr;

  assign w_tick = r_vs_prev & ~vsync_i;
  assign w_bx   = {2'b00, r_box_x};
  assign w_by   = {2'b00, r_box_y};
  assign w_xc   = {2'b00, xcol_i};
  assign w_yr   = {2'b00, yrow_i};

  // 13-bit sums leave headroom so box + size + step can never wrap
  always_comb begin
    w_nx  = r_box_x;
    w_ny  = r_box_y;
    w_ndx = r_dir_x;
    w_ndy = r_dir_y;
    if (r_dir_x) begin
      if (w_bx + c_BOX + c_STEP > c_H_DISP) begin
        w_nx  = c_X_MAX;
        w_ndx = 1'b0;
      end else begin
        w_nx  = r_box_x + c_STEP11;
      end
    end else begin
      if (w_bx < c_STEP) begin
        w_nx  = 11'd0;
        w_ndx = 1'b1;
      end else begin
        w_nx  = r_box_x - c_STEP11;
      end
    end
    if (r_dir_y) begin
      if (w_by + c_BOX + c_STEP > c_V_DISP) begin
        w_ny  = c_Y_MAX;
        w_ndy = 1'b0;
      end else begin
        w_ny  = r_box_y + c_STEP11;
      end
    end else begin
      if (w_by < c_STEP) begin
        w_ny  = 11'd0;
        w_ndy = 1'b1;
      end else begin
        w_ny  = r_box_y - c_STEP11;
      end
    end
  end

  assign w_hit = disp_active_i &
                 (w_xc >= w_bx) & (w_xc < w_bx + c_BOX) &
                 (w_yr >= w_by) & (w_yr < w_by + c_BOX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_box_x   <= 11'd0;
      r_box_y   <= 11'd0;
      r_dir_x   <= 1'b1;
      r_dir_y   <= 1'b1;
      r_vs_prev <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_vs_prev <= vsync_i;
      r_tick    <= w_tick;
      if (w_tick && move_en_i) begin
        r_box_x <= w_nx;
        r_box_y <= w_ny;
        r_dir_x <= w_ndx;
        r_dir_y <= w_ndy;
      end
    end
  end

`ifdef VGA_BORDER_EN
  logic r_edge;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_edge <= 1'b0;
    end else begin
      r_edge <= (xcol_i == 11'd0) | (xcol_i == 11'(H_DISP - 1)) |
                (yrow_i == 11'd0) | (yrow_i == 11'(V_DISP - 1));
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit  <= 1'b0;
      r_act  <= 1'b0;
      r_hs_d <= 2'b11;
      r_vs_d <= 2'b11;
      r_rgb  <= 12'h000;
    end else begin
      r_hit  <= w_hit;
      r_act  <= disp_active_i;
      r_hs_d <= {r_hs_d[0], hsync_i};
      r_vs_d <= {r_vs_d[0], vsync_i};
      if (!r_act) begin
        r_rgb <= 12'h000;
`ifdef VGA_BORDER_EN
      end else if (r_edge) begin
        r_rgb <= 12'hFFF;
`endif
      end else if (r_hit) begin
        r_rgb <= BOX_COLOR;
      end else begin
        r_rgb <= BG_COLOR;
      end
    end
  end

  assign hsync_o      = r_hs_d[1];
  assign vsync_o      = r_vs_d[1];
  assign red_o        = r_rgb[11:8];
  assign green_o      = r_rgb[7:4];
  assign blue_o       = r_rgb[3:0];
  assign frame_tick_o = r_tick;

endmodule

`default_nettype wire
